fetch_decode_queue: RTL and testbench

- Instruction queue between fetch and decode stage 1 (Format_Decoder).
- Buffers fetched instruction words with their address, PID and TID.
- Assigns each accepted instruction a 64-bit major ID.
- Presents one instruction per cycle to decode stage 1 and honours its stall.

---
 rtl/fetch_decode_queue_pkg.sv | 31 +++
 rtl/fetch_queue_storage.sv | 29 ++
 rtl/fetch_decode_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_decode_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// Shared decode definitions: default field widths, queue entry layout, instruction format codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_decode_queue_pkg;

   localparam int FDQ_ADDRESS_WIDTH     = 64;
   localparam int FDQ_INSTRUCTION_WIDTH = 32;
   localparam int FDQ_PID_SIZE          = 20;
   localparam int FDQ_TID_SIZE          = 16;
   localparam int FDQ_COUNTER_WIDTH     = 64;

   // One buffered fetch, as seen by decode stage 1.
   typedef struct packed {
      logic [FDQ_INSTRUCTION_WIDTH-1:0] instruction;
      logic [FDQ_ADDRESS_WIDTH-1:0]     address;
      logic [FDQ_PID_SIZE-1:0]          pid;
      logic [FDQ_TID_SIZE-1:0]          tid;
      logic [FDQ_COUNTER_WIDTH-1:0]     majId;
   } fdq_entry_t;

   // Instruction format one-hot codes shared by the decode stages.
   localparam logic [7:0] FMT_I  = 8'b0000_0001;
   localparam logic [7:0] FMT_B  = 8'b0000_0010;
   localparam logic [7:0] FMT_SC = 8'b0000_0100;
   localparam logic [7:0] FMT_D  = 8'b0000_1000;
   localparam logic [7:0] FMT_DS = 8'b0001_0000;
   localparam logic [7:0] FMT_X  = 8'b0010_0000;
   localparam logic [7:0] FMT_XO = 8'b0100_0000;
   localparam logic [7:0] FMT_M  = 8'b1000_0000;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry register array for the fetch/decode queue: one write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the controller only writes free slots and reads valid ones.
module fetch_queue_storage
   import fetch_decode_queue_pkg::*;
#(
   parameter int  depth   = 8,
   parameter type entry_t = fdq_entry_t
) (
   input  logic                     clock_i,
   input  logic                     wrEn_i,
   input  logic [$clog2(depth)-1:0] wrAddr_i,
   input  entry_t                   wrData_i,
   input  logic [$clog2(depth)-1:0] rdAddr_i,
   output entry_t                   rdData_o
);

   entry_t mem_q [depth];

   // Data storage carries no reset; validity is tracked by the controller's count.
   always_ff @(posedge clock_i) begin
      if (wrEn_i) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
   end

   assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue assigning a 64-bit major ID per accepted fetch; optional FETCH_DECODE_QUEUE_STATS_EN adds droppedCount_o.
// Latency: one cycle from the push edge to the outputs when not stalled; no input-to-output bypass.
// Backpressure: full_o drops pushes (fetch retries); stall_i freezes the registered outputs.
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int addressWidth            = FDQ_ADDRESS_WIDTH,
   parameter int instructionWidth        = FDQ_INSTRUCTION_WIDTH,
   parameter int PidSize                 = FDQ_PID_SIZE,
   parameter int TidSize                 = FDQ_TID_SIZE,
   parameter int instructionCounterWidth = FDQ_COUNTER_WIDTH,
   parameter int queueDepth              = 8
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               enable_i,
   input  logic                               flush_i,
   input  logic                               stall_i,
   input  logic [instructionWidth-1:0]        instruction_i,
   input  logic [addressWidth-1:0]            instructionAddress_i,
   input  logic [PidSize-1:0]                 instructionPid_i,
   input  logic [TidSize-1:0]                 instructionTid_i,
   output logic                               full_o,
   output logic                               outputEnable_o,
   output logic [instructionWidth-1:0]        instruction_o,
   output logic [addressWidth-1:0]            instructionAddress_o,
   output logic [PidSize-1:0]                 instructionPid_o,
   output logic [TidSize-1:0]                 instructionTid_o,
   output logic [instructionCounterWidth-1:0] instructionMajId_o
`ifdef FETCH_DECODE_QUEUE_STATS_EN
   ,
   output logic [31:0]                        droppedCount_o
`endif
);

   localparam int PtrWidth = $clog2(queueDepth);
   localparam int CntWidth = PtrWidth + 1;
   localparam logic [CntWidth-1:0] DepthCount = CntWidth'(queueDepth);

   typedef struct packed {
      logic [instructionWidth-1:0]        instruction;
      logic [addressWidth-1:0]            address;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic [instructionCounterWidth-1:0] majId;
   } entry_t;

   logic [PtrWidth-1:0]                head_q, head_d, tail_q, tail_d;
   logic [CntWidth-1:0]                count_q, count_d;
   logic [instructionCounterWidth-1:0] majId_q, majId_d;
   entry_t                             out_q, out_d;
   logic                               outValid_q, outValid_d;
   entry_t                             wrEntry, rdEntry;
   logic                               push, pop;

   // Full is taken from pre-edge state, so a same-cycle pop never frees a slot for a push.
   assign full_o = (count_q == DepthCount);
   assign push   = enable_i && !full_o && !flush_i;
   assign pop    = !stall_i && (count_q != '0) && !flush_i;

   assign wrEntry = '{instruction: instruction_i, address: instructionAddress_i,
                      pid: instructionPid_i, tid: instructionTid_i, majId: majId_q};

   fetch_queue_storage #(
      .depth   (queueDepth),
      .entry_t (entry_t)
   ) u_storage (
      .clock_i  (clock_i),
      .wrEn_i   (push),
      .wrAddr_i (tail_q),
      .wrData_i (wrEntry),
      .rdAddr_i (head_q),
      .rdData_o (rdEntry)
   );

   // Next-state: flush wins; otherwise push at tail, pop head into the output registers.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      majId_d    = majId_q;
      out_d      = out_q;
      outValid_d = outValid_q;
      if (flush_i) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         outValid_d = 1'b0;
      end else begin
         if (push) begin
            tail_d  = tail_q + PtrWidth'(1);
            majId_d = majId_q + instructionCounterWidth'(1);
         end
         if (!stall_i) begin
            outValid_d = (count_q != '0);
         end
         if (pop) begin
            out_d  = rdEntry;
            head_d = head_q + PtrWidth'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         majId_q    <= '0;
         out_q      <= '0;
         outValid_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         majId_q    <= majId_d;
         out_q      <= out_d;
         outValid_q <= outValid_d;
      end
   end

   assign outputEnable_o       = outValid_q;
   assign instruction_o        = out_q.instruction;
   assign instructionAddress_o = out_q.address;
   assign instructionPid_o     = out_q.pid;
   assign instructionTid_o     = out_q.tid;
   assign instructionMajId_o   = out_q.majId;

`ifdef FETCH_DECODE_QUEUE_STATS_EN
   logic [31:0] droppedCount_q;

   // Saturating count of pushes refused because the queue was full; flush leaves it alone.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         droppedCount_q <= '0;
      end else if (enable_i && full_o && !flush_i && (droppedCount_q != '1)) begin
         droppedCount_q <= droppedCount_q + 32'd1;
      end
   end

   assign droppedCount_o = droppedCount_q;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised plus directed bench for fetch_decode_queue with a queue-based reference model and scoreboard.
// Latency: model expects each accepted fetch on the outputs after the next unstalled edge.
// Backpressure: model drops pushes when holding queueDepth entries and freezes outputs on stall.
module tb_fetch_decode_queue;

   localparam int D = 8;

   typedef struct packed {
      logic [31:0] ins;
      logic [63:0] addr;
      logic [19:0] pid;
      logic [15:0] tid;
      logic [63:0] mid;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_i = 1'b0, flush_i = 1'b0, stall_i = 1'b0;
   logic [31:0] instruction_i = '0;
   logic [63:0] instructionAddress_i = '0;
   logic [19:0] instructionPid_i = '0;
   logic [15:0] instructionTid_i = '0;
   logic        full_o, outputEnable_o;
   logic [31:0] instruction_o;
   logic [63:0] instructionAddress_o;
   logic [19:0] instructionPid_o;
   logic [15:0] instructionTid_o;
   logic [63:0] instructionMajId_o;
`ifdef FETCH_DECODE_QUEUE_STATS_EN
   logic [31:0] droppedCount_o;
`endif

   always #5 clk = ~clk;

   fetch_decode_queue #(.queueDepth(D)) dut (
      .clock_i              (clk),
      .reset_i              (rst),
      .enable_i             (enable_i),
      .flush_i              (flush_i),
      .stall_i              (stall_i),
      .instruction_i        (instruction_i),
      .instructionAddress_i (instructionAddress_i),
      .instructionPid_i     (instructionPid_i),
      .instructionTid_i     (instructionTid_i),
      .full_o               (full_o),
      .outputEnable_o       (outputEnable_o),
      .instruction_o        (instruction_o),
      .instructionAddress_o (instructionAddress_o),
      .instructionPid_o     (instructionPid_o),
      .instructionTid_o     (instructionTid_o),
      .instructionMajId_o   (instructionMajId_o)
`ifdef FETCH_DECODE_QUEUE_STATS_EN
      ,
      .droppedCount_o       (droppedCount_o)
`endif
   );

   int          checks = 0;
   int          failures = 0;
   item_t       model_q[$];
   item_t       sb_q[$];
   logic [63:0] next_id = '0;
   logic        exp_oe = 1'b0;
   int          exp_dropped = 0;
   int          pre_size;
   item_t       last_out = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic item_t cur_out();
      return '{instruction_o, instructionAddress_o, instructionPid_o,
               instructionTid_o, instructionMajId_o};
   endfunction

   // Reference model: a plain FIFO of items; pops go to the scoreboard.
   always @(posedge clk) begin
      if (!rst) begin
         pre_size = model_q.size();
         if (flush_i) begin
            model_q.delete();
            exp_oe = 1'b0;
         end else begin
            if (enable_i && pre_size == D) exp_dropped++;
            if (!stall_i) begin
               if (pre_size > 0) begin
                  sb_q.push_back(model_q.pop_front());
                  exp_oe = 1'b1;
               end else begin
                  exp_oe = 1'b0;
               end
            end
            if (enable_i && pre_size < D) begin
               model_q.push_back('{instruction_i, instructionAddress_i, instructionPid_i,
                                   instructionTid_i, next_id});
               next_id++;
            end
         end
      end
   end

   // Monitor: compares each new presentation with the scoreboard and checks holds during stall.
   always @(posedge clk) begin
      logic  st, fl, rs;
      item_t e;
      st = stall_i;
      fl = flush_i;
      rs = rst;
      #1;
      if (!rs && !rst) begin
         chk("valid", outputEnable_o, exp_oe);
         chk("full", full_o, model_q.size() == D);
`ifdef FETCH_DECODE_QUEUE_STATS_EN
         chk("dropped", droppedCount_o, exp_dropped);
`endif
         if (st && !fl) begin
            chk("stall_hold", cur_out(), last_out);
         end else if (!st && !fl && outputEnable_o) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", cur_out(), '0);
               if (cur_out() == '0) begin
                  failures++;
                  $display("FAIL unexpected_output actual=valid required=no_output");
               end
            end else begin
               e = sb_q.pop_front();
               chk("data", cur_out(), e);
            end
         end
         last_out = cur_out();
      end
   end

   task automatic cyc(input logic en, input logic st, input logic fl, input logic [31:0] ins,
                      input logic [63:0] addr, input logic [19:0] pid, input logic [15:0] tid);
      @(negedge clk);
      enable_i = en; stall_i = st; flush_i = fl;
      instruction_i = ins; instructionAddress_i = addr;
      instructionPid_i = pid; instructionTid_i = tid;
   endtask

   task automatic rcyc(input logic en, input logic st, input logic fl);
      cyc(en, st, fl, $urandom, {$urandom, $urandom}, 20'($urandom), 16'($urandom));
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid", outputEnable_o, 1'b0);
      chk("rst_full", full_o, 1'b0);
      chk("rst_data", cur_out(), '0);
`ifdef FETCH_DECODE_QUEUE_STATS_EN
      chk("rst_dropped", droppedCount_o, 0);
`endif
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) rcyc(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #12;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Single pass.
      cyc(1'b1, 1'b0, 1'b0, 32'h4800_0000, 64'h100, 20'd5, 16'd2);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      @(posedge clk); #2;
      chk("single_valid", outputEnable_o, 1'b1);
      chk("single_word", instruction_o, 32'h4800_0000);
      chk("single_majid", instructionMajId_o, 64'd0);
      drain(3);

      // Fill with stall, then overflow push.
      for (int i = 0; i < D; i++) rcyc(1'b1, 1'b1, 1'b0);
      @(posedge clk); #2;
      chk("fill_full", full_o, 1'b1);
      rcyc(1'b1, 1'b1, 1'b0);
      @(posedge clk); #2;
      chk("fill_still_full", full_o, 1'b1);
`ifdef FETCH_DECODE_QUEUE_STATS_EN
      chk("fill_dropped", droppedCount_o, 32'd1);
`endif
      drain(D + 3);

      // Stall hold while a valid instruction is presented.
      for (int i = 0; i < 6; i++) rcyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) rcyc(1'b0, 1'b1, 1'b0);
      drain(4);

      // Flush with a same-cycle push, then a fresh push.
      for (int i = 0; i < 4; i++) rcyc(1'b1, 1'b1, 1'b0);
      rcyc(1'b1, 1'b0, 1'b1);
      rcyc(1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("flush_valid", outputEnable_o, 1'b0);
      chk("flush_full", full_o, 1'b0);
      rcyc(1'b1, 1'b0, 1'b0);
      drain(3);

      // Flush while stalled with valid outputs.
      for (int i = 0; i < 3; i++) rcyc(1'b1, 1'b0, 1'b0);
      rcyc(1'b0, 1'b1, 1'b1);
      drain(3);

      // Steady-state push/pop pairs across pointer wrap.
      for (int i = 0; i < 21; i++) rcyc(1'b1, 1'b0, 1'b0);
      drain(3);

      // Asynchronous reset with entries queued.
      for (int i = 0; i < 3; i++) rcyc(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      enable_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      #2;
      rst = 1'b1;
      model_q.delete(); sb_q.delete();
      next_id = '0; exp_oe = 1'b0; exp_dropped = 0; last_out = '0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      rcyc(1'b1, 1'b0, 1'b0);
      rcyc(1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("post_reset_majid", instructionMajId_o, 64'd0);
      chk("post_reset_valid", outputEnable_o, 1'b1);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         rcyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3);
      end
      drain(D + 4);

      chk("leftover_scoreboard", sb_q.size(), 0);
      chk("leftover_model", model_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
